// File: rtl/mem_resp_model.sv
// Single-port memory responder for the Addr/DataIn/Rd/Wr request protocol.
// One open line gives 1-cycle hits; every other access is a MISS_LAT-cycle miss that stalls.
module mem_resp_model #(
  parameter int unsigned MEM_AW   = 12,
  parameter int unsigned MISS_LAT = 4,
  parameter int unsigned LINE_AW  = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic [15:0] DataIn,
  input  logic        Rd,
  input  logic        Wr,
  output logic [15:0] DataOut,
  output logic        Done,
  output logic        Stall,
  output logic        CacheHit,
  output logic        Err
);

  localparam int unsigned TAG_W = 15 - LINE_AW;

  if (MISS_LAT < 3 || MISS_LAT > 20) begin : g_bad_miss_lat
    $error("mem_resp_model: MISS_LAT must lie in 3..20");
  end

  typedef enum logic [1:0] {IDLE, HIT_RSP, MISS, MISS_RSP} state_t;

  state_t             state, state_d;
  logic [4:0]         cnt;
  logic               open_valid;
  logic [TAG_W-1:0]   open_tag;
  logic [15:1]        lat_addr;
  logic [15:0]        lat_data;
  logic               lat_wr;
  logic               err_q;
  logic [15:0]        dout;

  logic [15:0]        mem [2**MEM_AW];

  logic [TAG_W-1:0]   tag_in;
  logic               illegal, hit, accept, last;
  logic               mem_we;
  logic [MEM_AW-1:0]  mem_idx;
  logic [15:0]        mem_wdata;

  logic unused_addr0;
  assign unused_addr0 = Addr[0];

  always_comb begin
    tag_in  = Addr[15:LINE_AW+1];
    illegal = Rd & Wr;
    hit     = open_valid && (tag_in == open_tag);
    accept  = (state != MISS) && (Rd | Wr);
    last    = (state == MISS) && (cnt == 5'd1);

    state_d = IDLE;
    case (state)
      MISS:    state_d = last ? MISS_RSP : MISS;
      default: if (accept) state_d = (illegal || hit) ? HIT_RSP : MISS;
    endcase

    // One array port: miss completion uses the latched request, otherwise the live one.
    mem_we    = 1'b0;
    mem_idx   = Addr[MEM_AW:1];
    mem_wdata = DataIn;
    if (last) begin
      mem_we    = lat_wr;
      mem_idx   = lat_addr[MEM_AW:1];
      mem_wdata = lat_data;
    end else if (accept && hit && !illegal && Wr) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) mem[mem_idx] <= mem_wdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      open_valid <= 1'b0;
      open_tag   <= '0;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_wr     <= 1'b0;
      err_q      <= 1'b0;
      dout       <= '0;
    end else begin
      state <= state_d;
      dout  <= '0;
      if (state == MISS) cnt <= cnt - 5'd1;
      if (last) begin
        if (!lat_wr) dout <= mem[mem_idx];
        open_tag   <= lat_addr[15:LINE_AW+1];
        open_valid <= 1'b1;
      end
      if (accept) begin
        err_q    <= illegal;
        lat_addr <= Addr[15:1];
        lat_data <= DataIn;
        lat_wr   <= Wr;
        if (illegal || hit) begin
          if (!illegal && !Wr) dout <= mem[mem_idx];
        end else begin
          cnt <= 5'(MISS_LAT - 1);
        end
      end
    end
  end

  assign Done     = (state == HIT_RSP) || (state == MISS_RSP);
  assign Stall    = (state == MISS);
  assign CacheHit = (state == HIT_RSP) && !err_q;
  assign Err      = (state == HIT_RSP) && err_q;
  assign DataOut  = dout;

endmodule

// File: tb/tb_mem_resp_model.sv
// Randomised and directed bench for mem_resp_model against a request-level
// reference model (word map + open-line tag, latency derived from hit/miss).
module tb_mem_resp_model;

  localparam int unsigned MEM_AW   = 12;
  localparam int unsigned MISS_LAT = 4;
  localparam int unsigned LINE_AW  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] DataIn = '0;
  logic        Rd = 1'b0;
  logic        Wr = 1'b0;
  logic [15:0] DataOut;
  logic        Done, Stall, CacheHit, Err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  mem_resp_model #(.MEM_AW(MEM_AW), .MISS_LAT(MISS_LAT), .LINE_AW(LINE_AW)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
    .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit), .Err(Err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          lat;
    int          stalls;
    int          spur;
    int          cyc;
    logic [15:0] dout;
    logic        hit;
    logic        err;
    logic        sd;
  } obs_t;

  typedef struct {
    int          lat;
    logic [15:0] dout;
    logic        hit;
    logic        err;
    logic        known;
  } exp_t;

  // Reference model: word contents by array index, plus the open line.
  logic [15:0] mm [int unsigned];
  bit          ov = 1'b0;
  int unsigned otag = 0;

  task automatic predict(input logic rd, input logic wr, input logic [15:0] a,
                         input logic [15:0] d, output exp_t e);
    int unsigned idx = (int'(a) >> 1) % (1 << MEM_AW);
    int unsigned tag = int'(a) >> (LINE_AW + 1);
    e.err   = rd && wr;
    e.hit   = !e.err && ov && (tag == otag);
    e.lat   = (e.err || e.hit) ? 1 : int'(MISS_LAT);
    e.dout  = '0;
    e.known = 1'b1;
    if (!e.err) begin
      if (wr) begin
        mm[idx] = d;
        e.known = 1'b0;
      end else if (mm.exists(idx)) begin
        e.dout = mm[idx];
      end else begin
        e.known = 1'b0;
      end
      if (!e.hit) begin
        otag = tag;
        ov   = 1'b1;
      end
    end
  endtask

  // Drives one request, scribbles on the inputs while stalled, and returns
  // what was seen up to and including the Done cycle.
  task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, output obs_t o);
    Rd = rd; Wr = wr; Addr = a; DataIn = d;
    @(posedge clk); #1;
    Rd = 1'b0; Wr = 1'b0;
    o = '{default: 0};
    o.lat = 1;
    while (!Done && o.lat < 40) begin
      if (CacheHit || Err) o.spur++;
      if (Stall) o.stalls++;
      Rd = 1'($urandom); Wr = 1'($urandom);
      Addr = 16'($urandom); DataIn = 16'($urandom);
      @(posedge clk); #1;
      Rd = 1'b0; Wr = 1'b0;
      o.lat++;
    end
    o.dout = DataOut; o.hit = CacheHit; o.err = Err; o.sd = Stall; o.cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks += 5;
    if (Done !== 1'b0)     begin errors++; $display("FAIL rst_done got %b exp 0", Done); end
    if (Stall !== 1'b0)    begin errors++; $display("FAIL rst_stall got %b exp 0", Stall); end
    if (CacheHit !== 1'b0) begin errors++; $display("FAIL rst_hit got %b exp 0", CacheHit); end
    if (Err !== 1'b0)      begin errors++; $display("FAIL rst_err got %b exp 0", Err); end
    if (DataOut !== 16'h0) begin errors++; $display("FAIL rst_dout got %h exp 0000", DataOut); end
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    checks++;
    if ({Done, Stall, CacheHit, Err} !== 4'b0) begin
      errors++; $display("FAIL idle_outputs got %b exp 0000", {Done, Stall, CacheHit, Err});
    end
  endtask

  task automatic test_hit_miss();
    logic [15:0] addrs [5] = '{16'h6000, 16'h6002, 16'h6000, 16'h7000, 16'h6000};
    logic        wrs   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      issue(!wrs[i], wrs[i], addrs[i], 16'hBEEF, o);
      predict(!wrs[i], wrs[i], addrs[i], 16'hBEEF, e);
      checks += 6;
      if (o.lat !== e.lat)        begin errors++; $display("FAIL hm_latency[%0d] got %0d exp %0d", i, o.lat, e.lat); end
      if (o.stalls !== e.lat - 1) begin errors++; $display("FAIL hm_stalls[%0d] got %0d exp %0d", i, o.stalls, e.lat - 1); end
      if (o.hit !== e.hit)        begin errors++; $display("FAIL hm_hit[%0d] got %b exp %b", i, o.hit, e.hit); end
      if (o.err !== e.err)        begin errors++; $display("FAIL hm_err[%0d] got %b exp %b", i, o.err, e.err); end
      if (o.sd !== 1'b0)          begin errors++; $display("FAIL hm_stall_at_done[%0d] got %b exp 0", i, o.sd); end
      if (o.spur !== 0)           begin errors++; $display("FAIL hm_stray_pulse[%0d] got %0d exp 0", i, o.spur); end
      if (e.known) begin
        checks++;
        if (o.dout !== e.dout) begin errors++; $display("FAIL hm_data[%0d] got %h exp %h", i, o.dout, e.dout); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [3] = '{16'h6000, 16'h6004, 16'h6004};
    logic        wrs   [3] = '{1'b0, 1'b1, 1'b0};
    obs_t o;
    exp_t e;
    int   prev_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      issue(!wrs[i], wrs[i], addrs[i], 16'h1234, o);
      predict(!wrs[i], wrs[i], addrs[i], 16'h1234, e);
      checks += 3;
      if (o.lat !== e.lat) begin errors++; $display("FAIL b2b_latency[%0d] got %0d exp %0d", i, o.lat, e.lat); end
      if (o.hit !== e.hit) begin errors++; $display("FAIL b2b_hit[%0d] got %b exp %b", i, o.hit, e.hit); end
      if (o.err !== e.err) begin errors++; $display("FAIL b2b_err[%0d] got %b exp %b", i, o.err, e.err); end
      if (i == 2) begin
        checks++;
        if (o.cyc - prev_cyc !== 1) begin errors++; $display("FAIL b2b_spacing got %0d exp 1", o.cyc - prev_cyc); end
      end
      if (e.known) begin
        checks++;
        if (o.dout !== e.dout) begin errors++; $display("FAIL b2b_data[%0d] got %h exp %h", i, o.dout, e.dout); end
      end
      prev_cyc = o.cyc;
    end
  endtask

  task automatic test_illegal();
    logic rds [2] = '{1'b1, 1'b1};
    logic wrs [2] = '{1'b1, 1'b0};
    obs_t o;
    exp_t e;
    for (int i = 0; i < 2; i++) begin
      issue(rds[i], wrs[i], 16'h6000, 16'hDEAD, o);
      predict(rds[i], wrs[i], 16'h6000, 16'hDEAD, e);
      checks += 4;
      if (o.lat !== e.lat) begin errors++; $display("FAIL ill_latency[%0d] got %0d exp %0d", i, o.lat, e.lat); end
      if (o.hit !== e.hit) begin errors++; $display("FAIL ill_hit[%0d] got %b exp %b", i, o.hit, e.hit); end
      if (o.err !== e.err) begin errors++; $display("FAIL ill_err[%0d] got %b exp %b", i, o.err, e.err); end
      if (o.dout !== e.dout) begin errors++; $display("FAIL ill_data[%0d] got %h exp %h", i, o.dout, e.dout); end
    end
  endtask

  task automatic test_reset_mid_miss();
    obs_t o;
    exp_t e;
    int   seen = 0;
    issue(1'b1, 1'b0, 16'h7000, 16'h0000, o);
    predict(1'b1, 1'b0, 16'h7000, 16'h0000, e);
    Rd = 1'b0; Wr = 1'b1; Addr = 16'h6000; DataIn = 16'h5555;
    @(posedge clk); #1;
    Wr = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (Stall !== 1'b1) begin errors++; $display("FAIL rmm_stall_before got %b exp 1", Stall); end
    rst = 1'b0;
    #1;
    checks++;
    if ({Done, Stall, CacheHit, Err, DataOut} !== 20'h0) begin
      errors++; $display("FAIL rmm_outputs got %b_%b_%b_%b_%h exp all 0", Done, Stall, CacheHit, Err, DataOut);
    end
    repeat (4) begin
      @(posedge clk); #1;
      if (Done) seen++;
    end
    rst = 1'b1;
    ov = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      if (Done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL rmm_no_done got %0d exp 0", seen); end
    issue(1'b1, 1'b0, 16'h6000, 16'h0000, o);
    predict(1'b1, 1'b0, 16'h6000, 16'h0000, e);
    checks += 3;
    if (o.lat !== int'(MISS_LAT)) begin errors++; $display("FAIL rmm_latency got %0d exp %0d", o.lat, MISS_LAT); end
    if (o.hit !== 1'b0)           begin errors++; $display("FAIL rmm_hit got %b exp 0", o.hit); end
    if (o.dout !== 16'hBEEF)      begin errors++; $display("FAIL rmm_data got %h exp beef", o.dout); end
  endtask

  task automatic test_random();
    logic [15:0] bases [4] = '{16'h6000, 16'h7000, 16'h1000, 16'h9000};
    obs_t        o;
    exp_t        e;
    logic        rd, wr;
    logic [15:0] a, d;
    int unsigned r;
    for (int i = 0; i < 200; i++) begin
      r  = $urandom_range(0, 9);
      rd = (r < 5) || (r == 9);
      wr = (r >= 5);
      a  = bases[$urandom_range(0, 3)] | 16'($urandom_range(0, 31));
      d  = 16'($urandom);
      issue(rd, wr, a, d, o);
      predict(rd, wr, a, d, e);
      checks += 5;
      if (o.lat !== e.lat)        begin errors++; $display("FAIL rnd_latency[%0d] a=%h got %0d exp %0d", i, a, o.lat, e.lat); end
      if (o.stalls !== e.lat - 1) begin errors++; $display("FAIL rnd_stalls[%0d] got %0d exp %0d", i, o.stalls, e.lat - 1); end
      if (o.hit !== e.hit)        begin errors++; $display("FAIL rnd_hit[%0d] a=%h got %b exp %b", i, a, o.hit, e.hit); end
      if (o.err !== e.err)        begin errors++; $display("FAIL rnd_err[%0d] got %b exp %b", i, o.err, e.err); end
      if (o.spur !== 0)           begin errors++; $display("FAIL rnd_stray_pulse[%0d] got %0d exp 0", i, o.spur); end
      if (e.known) begin
        checks++;
        if (o.dout !== e.dout) begin errors++; $display("FAIL rnd_data[%0d] a=%h got %h exp %h", i, a, o.dout, e.dout); end
      end
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
        checks++;
        if ({Done, CacheHit, Err} !== 3'b0) begin
          errors++; $display("FAIL rnd_pulse_width[%0d] got %b exp 000", i, {Done, CacheHit, Err});
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_hit_miss();
    test_back_to_back();
    test_illegal();
    test_reset_mid_miss();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
